// File: rtl/coin_pulse_conditioner_if.sv
// Coin conditioner signal bundle: raw buttons and vblank in, conditioned pulses and
// status out.
interface coin_pulse_conditioner_if #(
  parameter int unsigned CHANNELS = 2
) ();
  logic                vblank;
  logic [CHANNELS-1:0] coin_in;
  logic [CHANNELS-1:0] coin_out;
  logic [CHANNELS-1:0] busy;
  logic [15:0]         coin_total;

  modport master (
    output vblank,
    output coin_in,
    input  coin_out,
    input  busy,
    input  coin_total
  );

  modport slave (
    input  vblank,
    input  coin_in,
    output coin_out,
    output busy,
    output coin_total
  );
endinterface

// File: rtl/coin_pulse_conditioner.sv
// Turns raw coin buttons into one frame-timed pulse per press, with a lockout gap,
// no repeat while held, and a saturating count of accepted coins.
module coin_pulse_conditioner #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned PULSE_FRAMES = 3,
  parameter int unsigned GAP_FRAMES   = 3,
  parameter int unsigned CNT_W        = 4
) (
  input logic                     clk_sys,
  input logic                     RESET,
  coin_pulse_conditioner_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StWaitRel} state_e;

  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntPulse = CNT_W'(PULSE_FRAMES);
  localparam logic [CNT_W-1:0] CntGap   = CNT_W'(GAP_FRAMES);

  logic [CHANNELS-1:0] s1_q, s2_q, s2_prev_q;
  logic [CHANNELS-1:0] press, accept;
  logic [CHANNELS-1:0] coin_out_dec, busy_dec;
  logic [1:0]          arm_q;
  logic                vb_d_q, frame_tick;
  logic [15:0]         coin_total_q, coin_total_d;
  logic [16:0]         total_sum;
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  assign frame_tick = bus.vblank & ~vb_d_q;
  assign press      = s2_q & ~s2_prev_q;

  // arm_q fills with ones once the sync chain holds real samples again after reset,
  // so a button held through reset is not mistaken for a release and then a press.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s2_prev_q    <= '0;
      arm_q        <= '0;
      vb_d_q       <= 1'b0;
      coin_total_q <= '0;
    end else begin
      s1_q         <= bus.coin_in;
      s2_q         <= s1_q;
      s2_prev_q    <= s2_q;
      arm_q        <= {arm_q[0], 1'b1};
      vb_d_q       <= bus.vblank;
      coin_total_q <= coin_total_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (RESET) begin
        state_q[i] <= StWaitRel;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      accept[i]  = 1'b0;
      unique case (state_q[i])
        StIdle: begin
          if (press[i]) begin
            state_d[i] = StPulse;
            cnt_d[i]   = CntPulse;
            accept[i]  = 1'b1;
          end
        end
        StPulse: begin
          if (frame_tick) begin
            if (cnt_q[i] == CntOne) begin
              state_d[i] = StGap;
              cnt_d[i]   = CntGap;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
        end
        StGap: begin
          if (frame_tick) begin
            cnt_d[i] = cnt_q[i] - CntOne;
            if (cnt_q[i] == CntOne) state_d[i] = StWaitRel;
          end
        end
        StWaitRel: begin
          if (arm_q[1] && !s2_q[i]) state_d[i] = StIdle;
        end
        default: state_d[i] = StWaitRel;
      endcase
    end
  end

  // Simultaneous accepts add together in one update, clamped at all-ones.
  always_comb begin
    total_sum = {1'b0, coin_total_q};
    for (int i = 0; i < CHANNELS; i++) begin
      total_sum = total_sum + 17'(accept[i]);
    end
    coin_total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      coin_out_dec[i] = (state_q[i] == StPulse);
      busy_dec[i]     = (state_q[i] != StIdle);
    end
  end

  assign bus.coin_out   = coin_out_dec;
  assign bus.busy       = busy_dec;
  assign bus.coin_total = coin_total_q;

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Self-checking bench for coin_pulse_conditioner: a pulse scoreboard keyed on
// coin_out rising edges plus per-scenario timing checks.
module tb_coin_pulse_conditioner;
  localparam int unsigned Channels = 2;
  localparam int unsigned FrameLen = 16;

  logic clk_sys = 1'b0;
  logic RESET   = 1'b1;

  coin_pulse_conditioner_if #(.CHANNELS(Channels)) bus ();

  coin_pulse_conditioner #(
    .CHANNELS    (Channels),
    .PULSE_FRAMES(3),
    .GAP_FRAMES  (3),
    .CNT_W       (4)
  ) dut (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned phase    = 0;
  int unsigned tick_total = 0;
  int unsigned pulse_ticks [2];
  logic [15:0] model_total = '0;
  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];
  logic        vb_s = 1'b0;
  logic        mon_tick;
  logic [1:0]  out_prev = '0;
  logic [15:0] mon_exp;
  bit          mon_have;

  // Free-running frame: vblank high for phases 0..3, rising edge at phase 0.
  initial begin
    bus.vblank = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      phase = (phase + 1) % FrameLen;
      bus.vblank = (phase < 4);
    end
  end

  // Monitor: counts frame ticks, pops the scoreboard on each pulse start and checks
  // pulse length in ticks on each pulse end.
  always @(negedge clk_sys) begin
    if (RESET) begin
      vb_s     = 1'b0;
      out_prev = '0;
      pulse_ticks[0] = 0;
      pulse_ticks[1] = 0;
    end else begin
      mon_tick = bus.vblank & ~vb_s;
      vb_s     = bus.vblank;
      if (mon_tick) tick_total++;
      for (int ch = 0; ch < 2; ch++) begin
        if (bus.coin_out[ch] === 1'b1 && !out_prev[ch]) begin
          mon_have = 1'b0;
          if (ch == 0 && sb0.size() > 0) begin mon_exp = sb0.pop_front(); mon_have = 1'b1; end
          if (ch == 1 && sb1.size() > 0) begin mon_exp = sb1.pop_front(); mon_have = 1'b1; end
          n_checks++;
          if (!mon_have) begin
            n_fail++;
            $display("FAIL unexpected_pulse ch%0d: got a pulse (coin_total=%h), required none",
                     ch, bus.coin_total);
          end else if (bus.coin_total !== mon_exp) begin
            n_fail++;
            $display("FAIL pulse_total ch%0d: got %h, required %h", ch, bus.coin_total, mon_exp);
          end
          pulse_ticks[ch] = 0;
        end
        if (bus.coin_out[ch] === 1'b1 && mon_tick) pulse_ticks[ch]++;
        if (bus.coin_out[ch] === 1'b0 && out_prev[ch]) begin
          n_checks++;
          if (pulse_ticks[ch] != 3) begin
            n_fail++;
            $display("FAIL pulse_len ch%0d: got %0d ticks, required 3", ch, pulse_ticks[ch]);
          end
        end
        out_prev[ch] = (bus.coin_out[ch] === 1'b1);
      end
    end
  end

  task automatic wait_mid_frame();
    do begin
      @(posedge clk_sys);
      #2;
    end while (phase != 8);
  endtask

  task automatic wait_ticks(input int unsigned target, output bit expired);
    int unsigned n = 0;
    do begin
      @(negedge clk_sys);
      #1;
      n++;
    end while (tick_total < target && n < 200);
    expired = (tick_total < target);
  endtask

  task automatic wait_idle(input logic [1:0] mask, output bit expired);
    int unsigned n = 0;
    do begin
      @(negedge clk_sys);
      #1;
      n++;
    end while ((bus.busy & mask) != 2'b00 && n < 600);
    expired = ((bus.busy & mask) != 2'b00);
  endtask

  task automatic do_reset();
    @(posedge clk_sys);
    #2;
    RESET = 1'b1;
    repeat (3) @(posedge clk_sys);
    #2;
    RESET = 1'b0;
    model_total = '0;
    sb0.delete();
    sb1.delete();
    repeat (5) @(posedge clk_sys);
  endtask

  task automatic press(input logic [1:0] mask);
    wait_mid_frame();
    bus.coin_in = bus.coin_in | mask;
    for (int ch = 0; ch < 2; ch++) begin
      if (mask[ch]) model_total = (model_total == 16'hFFFF) ? model_total : model_total + 16'd1;
    end
    if (mask[0]) sb0.push_back(model_total);
    if (mask[1]) sb1.push_back(model_total);
    repeat (4) @(posedge clk_sys);
    #2;
    bus.coin_in = bus.coin_in & ~mask;
  endtask

  task automatic test_reset();
    bit expired;
    RESET = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.coin_out !== 2'b00) begin
      n_fail++; $display("FAIL reset_coin_out: got %b, required 00", bus.coin_out);
    end
    n_checks++;
    if (bus.busy !== 2'b11) begin
      n_fail++; $display("FAIL reset_busy: got %b, required 11", bus.busy);
    end
    n_checks++;
    if (bus.coin_total !== 16'h0000) begin
      n_fail++; $display("FAIL reset_total: got %h, required 0000", bus.coin_total);
    end
    n_checks++;
    if (dut.cnt_q[0] !== 4'd0 || dut.cnt_q[1] !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d, required 0/0", dut.cnt_q[0], dut.cnt_q[1]);
    end
    @(posedge clk_sys);
    #2;
    RESET = 1'b0;
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.busy !== 2'b11) begin
      n_fail++; $display("FAIL post_reset_busy: got %b, required 11", bus.busy);
    end
    wait_idle(2'b11, expired);
    n_checks++;
    if (expired) begin
      n_fail++; $display("FAIL reset_to_idle: got busy=%b, required 00", bus.busy);
    end
  endtask

  task automatic test_tap();
    bit expired;
    int unsigned t0;
    do_reset();
    wait_mid_frame();
    bus.coin_in[0] = 1'b1;
    model_total = model_total + 16'd1;
    sb0.push_back(model_total);
    t0 = tick_total;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      #1;
      n_checks++;
      if (bus.coin_out[0] !== (k == 3)) begin
        n_fail++;
        $display("FAIL tap_latency cycle %0d: got %b, required %b", k, bus.coin_out[0], k == 3);
      end
    end
    repeat (2) @(posedge clk_sys);
    #2;
    bus.coin_in[0] = 1'b0;
    wait_ticks(t0 + 3, expired);
    n_checks++;
    if (expired || bus.coin_out[0] !== 1'b1) begin
      n_fail++; $display("FAIL tap_high_at_tick3: got %b, required 1", bus.coin_out[0]);
    end
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.coin_out[0] !== 1'b0 || bus.coin_total !== 16'd1) begin
      n_fail++;
      $display("FAIL tap_fall: got out=%b total=%h, required out=0 total=0001",
               bus.coin_out[0], bus.coin_total);
    end
    wait_ticks(t0 + 6, expired);
    n_checks++;
    if (expired || bus.busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL tap_busy_tick6: got %b, required 1", bus.busy[0]);
    end
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL tap_busy_waitrel: got %b, required 1", bus.busy[0]);
    end
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL tap_busy_clear: got %b, required 0", bus.busy[0]);
    end
  endtask

  task automatic test_hold();
    bit expired;
    do_reset();
    wait_mid_frame();
    bus.coin_in[0] = 1'b1;
    model_total = model_total + 16'd1;
    sb0.push_back(model_total);
    repeat (20 * FrameLen) @(posedge clk_sys);
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.coin_total !== 16'd1 || bus.busy[0] !== 1'b1 || bus.coin_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_single: got total=%h busy=%b out=%b, required 0001/1/0",
               bus.coin_total, bus.busy[0], bus.coin_out[0]);
    end
    @(posedge clk_sys);
    #2;
    bus.coin_in[0] = 1'b0;
    wait_idle(2'b01, expired);
    n_checks++;
    if (expired) begin
      n_fail++; $display("FAIL hold_release: got busy=%b, required 0", bus.busy[0]);
    end
  endtask

  task automatic test_both();
    bit diverged = 1'b0;
    int unsigned n = 0;
    do_reset();
    press(2'b11);
    do begin
      @(negedge clk_sys);
      #1;
      if (bus.coin_out[0] !== bus.coin_out[1] || bus.busy[0] !== bus.busy[1]) diverged = 1'b1;
      n++;
    end while (bus.busy != 2'b00 && n < 600);
    n_checks++;
    if (diverged || bus.busy != 2'b00) begin
      n_fail++;
      $display("FAIL both_lockstep: got diverged=%b busy=%b, required 0/00", diverged, bus.busy);
    end
    n_checks++;
    if (bus.coin_total !== 16'd2) begin
      n_fail++; $display("FAIL both_total: got %h, required 0002", bus.coin_total);
    end
  endtask

  task automatic test_regap();
    bit expired;
    int unsigned t0;
    do_reset();
    press(2'b01);
    t0 = tick_total;
    wait_ticks(t0 + 4, expired);
    n_checks++;
    if (expired || {bus.coin_out[0], bus.busy[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL regap_in_gap: got out/busy=%b%b, required 01", bus.coin_out[0], bus.busy[0]);
    end
    @(posedge clk_sys);
    #2;
    bus.coin_in[0] = 1'b1;
    repeat (4) @(posedge clk_sys);
    #2;
    bus.coin_in[0] = 1'b0;
    wait_idle(2'b01, expired);
    n_checks++;
    if (expired || bus.coin_total !== 16'd1) begin
      n_fail++; $display("FAIL regap_ignored: got total=%h, required 0001", bus.coin_total);
    end
    press(2'b01);
    wait_idle(2'b01, expired);
    n_checks++;
    if (expired || bus.coin_total !== 16'd2) begin
      n_fail++; $display("FAIL regap_second: got total=%h, required 0002", bus.coin_total);
    end
  endtask

  task automatic test_hold_through_reset();
    bit expired;
    @(posedge clk_sys);
    #2;
    RESET = 1'b1;
    bus.coin_in[0] = 1'b1;
    repeat (3) @(posedge clk_sys);
    #2;
    RESET = 1'b0;
    model_total = '0;
    sb0.delete();
    sb1.delete();
    repeat (2 * FrameLen) @(posedge clk_sys);
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.coin_total !== 16'd0 || bus.busy[0] !== 1'b1 || bus.coin_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL held_reset_nocoin: got total=%h busy=%b out=%b, required 0000/1/0",
               bus.coin_total, bus.busy[0], bus.coin_out[0]);
    end
    @(posedge clk_sys);
    #2;
    bus.coin_in[0] = 1'b0;
    wait_idle(2'b01, expired);
    n_checks++;
    if (expired) begin
      n_fail++; $display("FAIL held_reset_release: got busy=%b, required 0", bus.busy[0]);
    end
    press(2'b01);
    wait_idle(2'b01, expired);
    n_checks++;
    if (expired || bus.coin_total !== 16'd1) begin
      n_fail++; $display("FAIL held_reset_second: got total=%h, required 0001", bus.coin_total);
    end
  endtask

  task automatic test_saturate();
    bit expired;
    do_reset();
    force dut.coin_total_q = 16'hFFFE;
    repeat (2) @(posedge clk_sys);
    #2;
    release dut.coin_total_q;
    model_total = 16'hFFFE;
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.coin_total !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_preload: got %h, required fffe", bus.coin_total);
    end
    press(2'b01);
    wait_idle(2'b11, expired);
    press(2'b10);
    wait_idle(2'b11, expired);
    press(2'b11);
    wait_idle(2'b11, expired);
    n_checks++;
    if (expired || bus.coin_total !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold: got %h, required ffff", bus.coin_total);
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    press(2'b01);
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.coin_out[0] !== 1'b1) begin
      n_fail++; $display("FAIL midpulse_pre: got %b, required 1", bus.coin_out[0]);
    end
    @(posedge clk_sys);
    #2;
    RESET = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus.coin_out[0] !== 1'b0) begin
      n_fail++; $display("FAIL midpulse_drop: got %b, required 0", bus.coin_out[0]);
    end
    n_checks++;
    if (dut.cnt_q[0] !== 4'd0 || bus.coin_total !== 16'd0) begin
      n_fail++;
      $display("FAIL midpulse_clear: got cnt=%0d total=%h, required 0/0000",
               dut.cnt_q[0], bus.coin_total);
    end
    @(posedge clk_sys);
    #2;
    RESET = 1'b0;
    model_total = '0;
    sb0.delete();
    sb1.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.coin_in = '0;
    test_reset();
    test_tap();
    test_hold();
    test_both();
    test_regap();
    test_hold_through_reset();
    test_saturate();
    test_reset_mid_pulse();
    repeat (4) @(posedge clk_sys);
    n_checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: got %0d/%0d pending, required 0/0", sb0.size(), sb1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
